// File: rtl/pos_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pos_arbiter
//  Purpose  : Frame-synchronous round-robin arbiter sharing the on-screen
//             object position between two position sources. Once per frame,
//             on the rising edge of vblnk, it grants at most one requester,
//             captures its coordinates through a valid/ready handshake,
//             clamps them to the visible area and commits them atomically.
//             The committed outputs only change during vertical blanking.
//  Ports    : pclk                 pixel clock, rising-edge logic
//             rst_n                asynchronous active-low reset
//             vblnk                vertical blank, synchronous to pclk
//             reqN_valid/x/y       requester N position offer (N = 0, 1)
//             reqN_ready           one-cycle accept strobe for requester N
//             xpos_out, ypos_out   committed position
//             owner                requester that made the last commit
//             frame_tick           pulse when a frame's arbitration completes
//  Revision : 1.0  initial release
// ============================================================================
module pos_arbiter #(
    parameter int unsigned X_LIM = 752,
    parameter int unsigned Y_LIM = 536
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        req0_valid,
    input  logic [11:0] req0_x,
    input  logic [11:0] req0_y,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_x,
    input  logic [11:0] req1_y,
    output logic        req1_ready,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        owner,
    output logic        frame_tick
);

    localparam logic [11:0] X_MAX = 12'(X_LIM);
    localparam logic [11:0] Y_MAX = 12'(Y_LIM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ACK    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        vblnk_q;
    logic        rr_q, rr_d;
    logic        win_q, win_d;
    logic        win_vld_q, win_vld_d;
    logic        rdy0_q, rdy0_d;
    logic        rdy1_q, rdy1_d;
    logic        tick_q, tick_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        owner_q, owner_d;

    logic        start;
    logic        sel_valid;
    logic [11:0] sel_x;
    logic [11:0] sel_y;
    logic [11:0] clamp_x;
    logic [11:0] clamp_y;

    // Only the rising edge of vblnk starts a frame, so a held vblnk never
    // retriggers arbitration.
    assign start = vblnk & ~vblnk_q;

    // Offer of the registered winner, sampled while its ready is high.
    assign sel_valid = win_q ? req1_valid : req0_valid;
    assign sel_x     = win_q ? req1_x     : req0_x;
    assign sel_y     = win_q ? req1_y     : req0_y;
    assign clamp_x   = (sel_x > X_MAX) ? X_MAX : sel_x;
    assign clamp_y   = (sel_y > Y_MAX) ? Y_MAX : sel_y;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        win_d     = win_q;
        win_vld_d = win_vld_q;
        rdy0_d    = 1'b0;
        rdy1_d    = 1'b0;
        tick_d    = 1'b0;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        owner_d   = owner_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!vblnk) begin
                    state_d = IDLE;
                end else begin
                    win_vld_d = req0_valid | req1_valid;
                    // Contention resolves to rr; a lone requester always wins.
                    win_d     = (req0_valid & req1_valid) ? rr_q : req1_valid;
                    rdy0_d    = win_vld_d & ~win_d;
                    rdy1_d    = win_vld_d &  win_d;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!vblnk) begin
                    state_d = IDLE;
                end else begin
                    // Capture and commit share the edge leaving ACK, so the
                    // new position appears together with frame_tick.
                    tick_d = 1'b1;
                    if (win_vld_q && sel_valid) begin
                        xpos_d  = clamp_x;
                        ypos_d  = clamp_y;
                        owner_d = win_q;
                        rr_d    = ~win_q;
                    end
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vblnk_q   <= 1'b0;
            rr_q      <= 1'b0;
            win_q     <= 1'b0;
            win_vld_q <= 1'b0;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            tick_q    <= 1'b0;
            xpos_q    <= 12'd0;
            ypos_q    <= 12'd0;
            owner_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblnk_q   <= vblnk;
            rr_q      <= rr_d;
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
            rdy0_q    <= rdy0_d;
            rdy1_q    <= rdy1_d;
            tick_q    <= tick_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            owner_q   <= owner_d;
        end
    end

    assign req0_ready = rdy0_q;
    assign req1_ready = rdy1_q;
    assign frame_tick = tick_q;
    assign xpos_out   = xpos_q;
    assign ypos_out   = ypos_q;
    assign owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_pos_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pos_arbiter
//  Purpose  : Self-checking bench for pos_arbiter: table of per-frame vectors
//             plus hand-written abort, dropped-valid and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pos_arbiter;

    logic        pclk;
    logic        rst_n;
    logic        vblnk;
    logic        req0_valid;
    logic [11:0] req0_x;
    logic [11:0] req0_y;
    logic        req0_ready;
    logic        req1_valid;
    logic [11:0] req1_x;
    logic [11:0] req1_y;
    logic        req1_ready;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;
    logic        owner;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    pos_arbiter #(.X_LIM(752), .Y_LIM(536)) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vblnk      (vblnk),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .xpos_out   (xpos_out),
        .ypos_out   (ypos_out),
        .owner      (owner),
        .frame_tick (frame_tick)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        r0v;
        logic [11:0] r0x;
        logic [11:0] r0y;
        logic        r1v;
        logic [11:0] r1x;
        logic [11:0] r1y;
        logic        e_rdy0;
        logic        e_rdy1;
        logic [11:0] e_x;
        logic [11:0] e_y;
        logic        e_own;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " rdy0"}, 32'(req0_ready), 0);
        chk({tag, " rdy1"}, 32'(req1_ready), 0);
        chk({tag, " tick"}, 32'(frame_tick), 0);
    endtask

    task automatic chk_pos(input string tag, input logic [11:0] x, input logic [11:0] y,
                           input logic own);
        chk({tag, " xpos"},  32'(xpos_out), 32'(x));
        chk({tag, " ypos"},  32'(ypos_out), 32'(y));
        chk({tag, " owner"}, 32'(owner),    32'(own));
    endtask

    task automatic set_reqs(input logic v0, input logic [11:0] x0, input logic [11:0] y0,
                            input logic v1, input logic [11:0] x1, input logic [11:0] y1);
        req0_valid = v0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_x = x1; req1_y = y1;
    endtask

    // One full frame: vblnk rises, E = next edge; ready at E+1, commit at E+2.
    task automatic run_frame(input string tag, input vec_t v);
        set_reqs(v.r0v, v.r0x, v.r0y, v.r1v, v.r1x, v.r1y);
        vblnk = 1'b1;
        step();                                   // E: ARB
        chk_quiet({tag, " E"});
        step();                                   // E+1: ACK
        chk({tag, " E+1 rdy0"}, 32'(req0_ready), 32'(v.e_rdy0));
        chk({tag, " E+1 rdy1"}, 32'(req1_ready), 32'(v.e_rdy1));
        chk({tag, " E+1 tick"}, 32'(frame_tick), 0);
        step();                                   // E+2: COMMIT
        chk({tag, " E+2 rdy0"}, 32'(req0_ready), 0);
        chk({tag, " E+2 rdy1"}, 32'(req1_ready), 0);
        chk({tag, " E+2 tick"}, 32'(frame_tick), 1);
        chk_pos({tag, " E+2"}, v.e_x, v.e_y, v.e_own);
        set_reqs(1'b0, 12'd0, 12'd0, 1'b0, 12'd0, 12'd0);
        step();                                   // E+3: IDLE, vblnk still high
        chk({tag, " E+3 tick"}, 32'(frame_tick), 0);
        step();
        chk_quiet({tag, " held"});
        vblnk = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        r0v r0x   r0y   r1v r1x   r1y    rdy0 rdy1 x    y    own
        tbl[0] = '{1'b1, 12'd10,  12'd20,  1'b1, 12'd30,  12'd40,   1'b1, 1'b0, 12'd10,  12'd20,  1'b0};
        tbl[1] = '{1'b1, 12'd10,  12'd20,  1'b1, 12'd30,  12'd40,   1'b0, 1'b1, 12'd30,  12'd40,  1'b1};
        tbl[2] = '{1'b1, 12'd10,  12'd20,  1'b1, 12'd30,  12'd40,   1'b1, 1'b0, 12'd10,  12'd20,  1'b0};
        tbl[3] = '{1'b1, 12'd100, 12'd200, 1'b0, 12'd0,   12'd0,    1'b1, 1'b0, 12'd100, 12'd200, 1'b0};
        tbl[4] = '{1'b0, 12'd0,   12'd0,   1'b1, 12'd900, 12'd4095, 1'b0, 1'b1, 12'd752, 12'd536, 1'b1};
        tbl[5] = '{1'b1, 12'd752, 12'd536, 1'b0, 12'd0,   12'd0,    1'b1, 1'b0, 12'd752, 12'd536, 1'b0};
        tbl[6] = '{1'b0, 12'd0,   12'd0,   1'b1, 12'd753, 12'd537,  1'b0, 1'b1, 12'd752, 12'd536, 1'b1};
        tbl[7] = '{1'b0, 12'd0,   12'd0,   1'b0, 12'd0,   12'd0,    1'b0, 1'b0, 12'd752, 12'd536, 1'b1};
        tbl[8] = '{1'b1, 12'd751, 12'd535, 1'b0, 12'd0,   12'd0,    1'b1, 1'b0, 12'd751, 12'd535, 1'b0};

        rst_n = 1'b0;
        vblnk = 1'b0;
        set_reqs(1'b0, 12'd0, 12'd0, 1'b0, 12'd0, 12'd0);
        step();
        step();
        chk_quiet("reset");
        chk_pos("reset", 12'd0, 12'd0, 1'b0);
        rst_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i]);
        end

        // Abort: vblnk high for a single cycle; rr stays 1 from vec8.
        set_reqs(1'b1, 12'd5, 12'd6, 1'b0, 12'd0, 12'd0);
        vblnk = 1'b1;
        step();                                   // E: ARB
        vblnk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet($sformatf("abort c%0d", i));
        end
        chk_pos("abort", 12'd751, 12'd535, 1'b0);
        // rr=1 unchanged, so contention goes to requester 1.
        run_frame("post_abort", '{1'b1, 12'd5, 12'd6, 1'b1, 12'd7, 12'd8,
                                   1'b0, 1'b1, 12'd7, 12'd8, 1'b1});

        // Dropped valid: req0 wins at ARB, drops valid during ACK.
        set_reqs(1'b1, 12'd9, 12'd9, 1'b0, 12'd0, 12'd0);
        vblnk = 1'b1;
        step();                                   // E
        step();                                   // E+1
        chk("drop E+1 rdy0", 32'(req0_ready), 1);
        req0_valid = 1'b0;
        step();                                   // E+2
        chk("drop E+2 tick", 32'(frame_tick), 1);
        chk_pos("drop E+2", 12'd7, 12'd8, 1'b1);
        step();
        vblnk = 1'b0;
        step();
        step();
        // rr still 0, so contention goes to requester 0.
        run_frame("post_drop", '{1'b1, 12'd11, 12'd12, 1'b1, 12'd13, 12'd14,
                                  1'b1, 1'b0, 12'd11, 12'd12, 1'b0});

        // Reset while in ACK with req1_ready high.
        set_reqs(1'b0, 12'd0, 12'd0, 1'b1, 12'd99, 12'd98);
        vblnk = 1'b1;
        step();                                   // E
        step();                                   // E+1: ACK
        chk("rst ACK rdy1", 32'(req1_ready), 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst async");
        chk_pos("rst async", 12'd0, 12'd0, 1'b0);
        vblnk = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet($sformatf("post_rst c%0d", i));
        end
        chk_pos("post_rst", 12'd0, 12'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
